// File: rtl/head_ptr_lookup.sv
// Head-pointer lookup stage: hashes command keys to buckets, reads the bucket head from the
// on-chip head RAM, and delivers enriched tasks to the data table with write-snoop coherence.
module head_ptr_lookup #(
  parameter int unsigned KEY_WIDTH      = 32,
  parameter int unsigned VALUE_WIDTH    = 16,
  parameter int unsigned BUCKET_WIDTH   = 8,
  parameter int unsigned HEAD_PTR_WIDTH = 8,
  parameter int unsigned RAM_LATENCY    = 2,
  parameter int unsigned OUT_DEPTH      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                cmd_opcode_i,
  input  logic [KEY_WIDTH-1:0]      cmd_key_i,
  input  logic [VALUE_WIDTH-1:0]    cmd_value_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  output logic [1:0]                pdata_opcode_o,
  output logic [KEY_WIDTH-1:0]      pdata_key_o,
  output logic [VALUE_WIDTH-1:0]    pdata_value_o,
  output logic [BUCKET_WIDTH-1:0]   pdata_bucket_o,
  output logic [HEAD_PTR_WIDTH-1:0] pdata_head_ptr_o,
  output logic                      pdata_head_ptr_val_o,
  output logic                      pdata_valid_o,
  input  logic                      pdata_ready_i,
  input  logic [BUCKET_WIDTH-1:0]   ht_wr_addr_i,
  input  logic [HEAD_PTR_WIDTH-1:0] ht_wr_ptr_i,
  input  logic                      ht_wr_ptr_val_i,
  input  logic                      ht_wr_en_i
);

  localparam int unsigned RAM_DEPTH = 2 ** BUCKET_WIDTH;
  localparam int unsigned NCH       = (KEY_WIDTH + BUCKET_WIDTH - 1) / BUCKET_WIDTH;
  localparam int unsigned PAD_W     = NCH * BUCKET_WIDTH;
  localparam int unsigned OCC_W     = $clog2(OUT_DEPTH + 1);
  localparam int unsigned IDX_W     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  typedef struct packed {
    logic [1:0]                opcode;
    logic [KEY_WIDTH-1:0]      key;
    logic [VALUE_WIDTH-1:0]    value;
    logic [BUCKET_WIDTH-1:0]   bucket;
    logic [HEAD_PTR_WIDTH-1:0] head_ptr;
    logic                      head_val;
  } task_t;

  typedef struct packed {
    logic [HEAD_PTR_WIDTH-1:0] ptr;
    logic                      val;
  } head_t;

  function automatic task_t snoop(input task_t t, input logic en,
                                  input logic [BUCKET_WIDTH-1:0] addr,
                                  input logic [HEAD_PTR_WIDTH-1:0] ptr, input logic val);
    task_t r;
    r = t;
    if (en && (t.bucket == addr)) begin
      r.head_ptr = ptr;
      r.head_val = val;
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(OUT_DEPTH - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  head_t                   mem    [RAM_DEPTH];
  head_t                   rd_q   [RAM_LATENCY];
  task_t                   pipe_q [RAM_LATENCY];
  logic [RAM_LATENCY-1:0]  pipe_ovr;
  logic [RAM_LATENCY-1:0]  pipe_v;
  logic [RAM_LATENCY-1:0]  pipe_v_next;
  task_t                   fifo_q [OUT_DEPTH];
  task_t                   out_q;
  logic                    out_v;

  logic [PAD_W-1:0]        key_pad;
  logic [BUCKET_WIDTH-1:0] bucket_in;
  task_t                   cmd_task;
  task_t                   fifo_in;
  logic                    wr_hit_in;
  logic                    accept;
  logic                    pop;
  logic                    fifo_wr;
  logic                    load;
  logic [OCC_W-1:0]        occ;
  logic [OCC_W-1:0]        occ_next;
  logic [OCC_W-1:0]        fcnt;
  logic [OCC_W-1:0]        fcnt_next;
  logic [IDX_W-1:0]        wr_idx;
  logic [IDX_W-1:0]        rd_idx;

  always_comb begin
    key_pad   = PAD_W'(cmd_key_i);
    bucket_in = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      bucket_in = bucket_in ^ key_pad[i*BUCKET_WIDTH +: BUCKET_WIDTH];
    end
  end

  assign accept    = cmd_valid_i & cmd_ready_o;
  assign pop       = out_v & pdata_ready_i;
  assign fifo_wr   = pipe_v[RAM_LATENCY-1];
  assign load      = (fcnt != '0) && (!out_v || pop);
  assign wr_hit_in = ht_wr_en_i && (bucket_in == ht_wr_addr_i);

  // Head fields of the accepted task hold the snooped write value; pipe_ovr selects it over RAM data.
  always_comb begin
    cmd_task          = '0;
    cmd_task.opcode   = cmd_opcode_i;
    cmd_task.key      = cmd_key_i;
    cmd_task.value    = cmd_value_i;
    cmd_task.bucket   = bucket_in;
    cmd_task.head_ptr = ht_wr_ptr_i;
    cmd_task.head_val = ht_wr_ptr_val_i;
  end

  always_comb begin
    fifo_in = pipe_q[RAM_LATENCY-1];
    if (!pipe_ovr[RAM_LATENCY-1]) begin
      fifo_in.head_ptr = rd_q[RAM_LATENCY-1].ptr;
      fifo_in.head_val = rd_q[RAM_LATENCY-1].val;
    end
    fifo_in = snoop(fifo_in, ht_wr_en_i, ht_wr_addr_i, ht_wr_ptr_i, ht_wr_ptr_val_i);
  end

  always_comb begin
    pipe_v_next    = '0;
    pipe_v_next[0] = accept;
    for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
      pipe_v_next[i] = pipe_v[i-1];
    end
  end

  always_comb begin
    occ_next = occ;
    if (accept && !pop)      occ_next = occ + OCC_W'(1);
    else if (!accept && pop) occ_next = occ - OCC_W'(1);
    fcnt_next = fcnt;
    if (fifo_wr && !load)      fcnt_next = fcnt + OCC_W'(1);
    else if (!fifo_wr && load) fcnt_next = fcnt - OCC_W'(1);
  end

  // Storage without reset: head RAM, read pipeline, task pipeline and FIFO array.
  always_ff @(posedge clk_i) begin
    if (ht_wr_en_i) mem[ht_wr_addr_i] <= '{ptr: ht_wr_ptr_i, val: ht_wr_ptr_val_i};
    rd_q[0]     <= mem[bucket_in];
    pipe_q[0]   <= cmd_task;
    pipe_ovr[0] <= wr_hit_in;
    for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
      rd_q[i]     <= rd_q[i-1];
      pipe_q[i]   <= snoop(pipe_q[i-1], ht_wr_en_i, ht_wr_addr_i, ht_wr_ptr_i, ht_wr_ptr_val_i);
      pipe_ovr[i] <= pipe_ovr[i-1] | (ht_wr_en_i && (pipe_q[i-1].bucket == ht_wr_addr_i));
    end
    for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
      fifo_q[i] <= snoop(fifo_q[i], ht_wr_en_i, ht_wr_addr_i, ht_wr_ptr_i, ht_wr_ptr_val_i);
    end
    if (fifo_wr) fifo_q[wr_idx] <= fifo_in;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ         <= '0;
      cmd_ready_o <= 1'b0;
      pipe_v      <= '0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      fcnt        <= '0;
      out_v       <= 1'b0;
      out_q       <= '0;
    end else begin
      occ         <= occ_next;
      cmd_ready_o <= (occ_next < OCC_W'(OUT_DEPTH));
      pipe_v      <= pipe_v_next;
      fcnt        <= fcnt_next;
      if (fifo_wr) wr_idx <= idx_inc(wr_idx);
      if (load) begin
        rd_idx <= idx_inc(rd_idx);
        out_q  <= snoop(fifo_q[rd_idx], ht_wr_en_i, ht_wr_addr_i, ht_wr_ptr_i, ht_wr_ptr_val_i);
      end else begin
        out_q  <= snoop(out_q, ht_wr_en_i, ht_wr_addr_i, ht_wr_ptr_i, ht_wr_ptr_val_i);
      end
      out_v <= load | (out_v & ~pop);
    end
  end

  assign pdata_opcode_o       = out_q.opcode;
  assign pdata_key_o          = out_q.key;
  assign pdata_value_o        = out_q.value;
  assign pdata_bucket_o       = out_q.bucket;
  assign pdata_head_ptr_o     = out_q.head_ptr;
  assign pdata_head_ptr_val_o = out_q.head_val;
  assign pdata_valid_o        = out_v;

endmodule

// File: tb/tb_head_ptr_lookup.sv
// Bench for head_ptr_lookup: random and directed commands against a bucket/head-table model,
// with a queue scoreboard checked by a separate output monitor.
module tb_head_ptr_lookup;
  localparam int KW = 32, VW = 16, BW = 8, PW = 8, LAT = 2, OD = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [1:0]    cmd_opcode_i;
  logic [KW-1:0] cmd_key_i;
  logic [VW-1:0] cmd_value_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [1:0]    pdata_opcode_o;
  logic [KW-1:0] pdata_key_o;
  logic [VW-1:0] pdata_value_o;
  logic [BW-1:0] pdata_bucket_o;
  logic [PW-1:0] pdata_head_ptr_o;
  logic          pdata_head_ptr_val_o;
  logic          pdata_valid_o;
  logic          pdata_ready_i;
  logic [BW-1:0] ht_wr_addr_i;
  logic [PW-1:0] ht_wr_ptr_i;
  logic          ht_wr_ptr_val_i;
  logic          ht_wr_en_i;

  head_ptr_lookup #(
    .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .BUCKET_WIDTH(BW),
    .HEAD_PTR_WIDTH(PW), .RAM_LATENCY(LAT), .OUT_DEPTH(OD)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_opcode_i(cmd_opcode_i), .cmd_key_i(cmd_key_i), .cmd_value_i(cmd_value_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .pdata_opcode_o(pdata_opcode_o), .pdata_key_o(pdata_key_o), .pdata_value_o(pdata_value_o),
    .pdata_bucket_o(pdata_bucket_o), .pdata_head_ptr_o(pdata_head_ptr_o),
    .pdata_head_ptr_val_o(pdata_head_ptr_val_o), .pdata_valid_o(pdata_valid_o),
    .pdata_ready_i(pdata_ready_i),
    .ht_wr_addr_i(ht_wr_addr_i), .ht_wr_ptr_i(ht_wr_ptr_i),
    .ht_wr_ptr_val_i(ht_wr_ptr_val_i), .ht_wr_en_i(ht_wr_en_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    op;
    logic [KW-1:0] key;
    logic [VW-1:0] val;
    logic [BW-1:0] bucket;
  } exp_t;

  exp_t        exp_q[$];
  logic [PW:0] ref_mem [256];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0]  last_bucket = '0;

  // Bucket = XOR of the four key bytes.
  function automatic logic [BW-1:0] ref_hash(input logic [KW-1:0] k);
    logic [BW-1:0] h = '0;
    for (int i = 0; i < 4; i++) h = h ^ 8'((k >> (8 * i)) & 32'hFF);
    return h;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) if (ht_wr_en_i) ref_mem[ht_wr_addr_i] <= {ht_wr_ptr_i, ht_wr_ptr_val_i};

  // Head fields expected = current head-table contents for the bucket at hand-off time.
  always @(negedge clk) begin
    if (!rst_i && pdata_valid_o && pdata_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_task: got key %0h bucket %0h, expected none", pdata_key_o, pdata_bucket_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("task", {pdata_opcode_o, pdata_key_o, pdata_value_o, pdata_bucket_o,
                       pdata_head_ptr_o, pdata_head_ptr_val_o},
                      {e.op, e.key, e.val, e.bucket, ref_mem[e.bucket]});
      end
    end
  end

  task automatic push_exp(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val);
    exp_t e;
    e.op = op; e.key = key; e.val = val; e.bucket = ref_hash(key);
    exp_q.push_back(e);
    last_bucket = e.bucket;
  endtask

  task automatic issue(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val);
    bit ok = 0;
    cmd_opcode_i = op; cmd_key_i = key; cmd_value_i = val; cmd_valid_i = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (cmd_ready_o) begin
        push_exp(op, key, val);
        step();
        ok = 1;
        break;
      end
      step();
    end
    cmd_valid_i = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_valid(input string name);
    bit ok = 0;
    for (int c = 0; c < 50; c++) begin
      if (pdata_valid_o) begin ok = 1; break; end
      step();
    end
    if (!ok) check(name, 0, 1);
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 500; c++) begin
      if (exp_q.size() == 0 && !pdata_valid_o) break;
      step();
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic ht_write(input logic [BW-1:0] a, input logic [PW-1:0] p, input logic v);
    ht_wr_en_i = 1'b1; ht_wr_addr_i = a; ht_wr_ptr_i = p; ht_wr_ptr_val_i = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned acc;
    int unsigned seen;
    int unsigned issued;
    logic [KW-1:0] keys [8];
    bit acc_now;

    rst_i = 1'b1; cmd_opcode_i = '0; cmd_key_i = '0; cmd_value_i = '0; cmd_valid_i = 1'b0;
    pdata_ready_i = 1'b0; ht_wr_addr_i = '0; ht_wr_ptr_i = '0; ht_wr_ptr_val_i = 1'b0; ht_wr_en_i = 1'b0;
    repeat (3) step();
    check("reset_outputs", {cmd_ready_o, pdata_valid_o, pdata_opcode_o, pdata_key_o, pdata_value_o,
                            pdata_bucket_o, pdata_head_ptr_o, pdata_head_ptr_val_o}, 0);
    rst_i = 1'b0;
    check("ready_before_edge", cmd_ready_o, 0);
    step();
    check("ready_after_release", cmd_ready_o, 1);

    for (int b = 0; b < 256; b++) begin
      ht_write(8'(b), 8'($urandom), 1'($urandom));
      step();
    end
    ht_wr_en_i = 1'b0;

    // Basic lookup and latency
    ht_write(8'h12, 8'h05, 1'b1);
    step();
    ht_wr_en_i = 1'b0;
    pdata_ready_i = 1'b1;
    issue(2'd1, 32'h0000_0012, 16'h1234);
    for (int k = 1; k <= LAT; k++) step();
    check("t1_valid_early", pdata_valid_o, 0);
    step();
    check("t1_lookup", {pdata_valid_o, pdata_bucket_o, pdata_head_ptr_o, pdata_head_ptr_val_o},
                       {1'b1, 8'h12, 8'h05, 1'b1});
    wait_drain("t1_drain");

    // Hash spot check
    issue(2'd1, 32'hA1B2_C3D4, 16'h0);
    wait_valid("t2_valid_timeout");
    check("t2_hash", pdata_bucket_o, 8'h04);
    wait_drain("t2_drain");

    // Back-pressure: only OUT_DEPTH accepted while output is stalled
    for (int i = 0; i < 8; i++) keys[i] = $urandom;
    pdata_ready_i = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      cmd_opcode_i = 2'(acc); cmd_key_i = keys[acc]; cmd_value_i = 16'(acc); cmd_valid_i = 1'b1;
      if (cmd_ready_o) begin push_exp(2'(acc), keys[acc], 16'(acc)); acc++; end
      step();
    end
    check("t3_accepted", acc, OD);
    check("t3_ready_low", cmd_ready_o, 0);
    pdata_ready_i = 1'b1;
    for (int c = 0; c < 100 && acc < 8; c++) begin
      cmd_opcode_i = 2'(acc); cmd_key_i = keys[acc]; cmd_value_i = 16'(acc); cmd_valid_i = 1'b1;
      if (cmd_ready_o) begin push_exp(2'(acc), keys[acc], 16'(acc)); acc++; end
      step();
    end
    cmd_valid_i = 1'b0;
    check("t3_all_accepted", acc, 8);
    wait_drain("t3_drain");

    // Snoop of the presented task
    pdata_ready_i = 1'b0;
    issue(2'd2, 32'h0000_0004, 16'hBEEF);
    wait_valid("t4_valid_timeout");
    ht_write(8'h04, 8'h3C, 1'b1);
    step();
    ht_wr_en_i = 1'b0;
    check("t4_snoop_hit", {pdata_head_ptr_o, pdata_head_ptr_val_o}, {8'h3C, 1'b1});
    ht_write(8'h05, 8'h77, 1'b0);
    step();
    ht_wr_en_i = 1'b0;
    check("t4_snoop_miss", {pdata_head_ptr_o, pdata_head_ptr_val_o}, {8'h3C, 1'b1});
    pdata_ready_i = 1'b1;
    wait_drain("t4_drain");

    // Write and accept on the same edge, same bucket
    ht_write(8'h07, 8'h22, 1'b0);
    step();
    ht_wr_en_i = 1'b0;
    step();
    ht_write(8'h07, 8'h11, 1'b1);
    issue(2'd1, 32'h0000_0007, 16'h0007);
    ht_wr_en_i = 1'b0;
    wait_valid("t5_valid_timeout");
    check("t5_same_edge", {pdata_head_ptr_o, pdata_head_ptr_val_o}, {8'h11, 1'b1});
    wait_drain("t5_drain");

    // Randomized traffic with random stalls and head-table writes
    issued = 0;
    acc_now = 0;
    for (int c = 0; c < 20000 && issued < 1000; c++) begin
      if (acc_now) cmd_valid_i = 1'b0;
      acc_now = 0;
      pdata_ready_i = ($urandom_range(0, 9) < 7);
      if (!cmd_valid_i && $urandom_range(0, 3) != 0) begin
        cmd_opcode_i = 2'($urandom);
        cmd_key_i    = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 15));
        cmd_value_i  = 16'($urandom);
        cmd_valid_i  = 1'b1;
      end
      if ($urandom_range(0, 4) == 0)
        ht_write(($urandom_range(0, 1) == 0) ? last_bucket : 8'($urandom), 8'($urandom), 1'($urandom));
      else
        ht_wr_en_i = 1'b0;
      if (cmd_valid_i && cmd_ready_o) begin
        push_exp(cmd_opcode_i, cmd_key_i, cmd_value_i);
        issued++;
        acc_now = 1;
      end
      step();
    end
    cmd_valid_i = 1'b0;
    ht_wr_en_i = 1'b0;
    check("rand_issued", issued, 1000);
    pdata_ready_i = 1'b1;
    wait_drain("rand_drain");

    // Reset with buffered tasks
    pdata_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) issue(2'd1, 32'($urandom), 16'(i));
    repeat (LAT + 2) step();
    check("t6_buffered_valid", pdata_valid_o, 1);
    rst_i = 1'b1;
    #1;
    check("t6_valid_drop", pdata_valid_o, 0);
    exp_q.delete();
    step();
    step();
    rst_i = 1'b0;
    step();
    check("t6_ready_after", cmd_ready_o, 1);
    pdata_ready_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (pdata_valid_o) seen++;
      step();
    end
    check("t6_no_stale", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
